synchronizer: RTL and testbench

- Parameterised multi-flop synchroniser for a LEN-bit bundle of asynchronous inputs, such as buttons, switches or external GPIO, into the clk domain.
- Also produces single-cycle per-bit rising-edge and falling-edge strobes, aligned with the cycle in which the synchronised output changes.
- Sits at the chip/peripheral boundary, feeding GPIO/interrupt logic.

---
 rtl/synchronizer_pkg.sv | 11 +
 rtl/synchronizer_stage.sv | 37 +++
 rtl/synchronizer.sv | 57 +++++
 tb/tb_synchronizer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/synchronizer_pkg.sv
// Shared limits for the input synchroniser.
// Imported by the stage and top modules.
package synchronizer_pkg;

  localparam int unsigned SYNC_MIN_LEN    = 1;
  localparam int unsigned SYNC_MIN_STAGES = 2;

  localparam int unsigned SYNC_DEF_LEN    = 1;
  localparam int unsigned SYNC_DEF_STAGES = 2;

endpackage

// File: rtl/synchronizer_stage.sv
// One LEN-wide enabled flop with async active-low clear.
// Chained to form the synchroniser and its history register.
module synchronizer_stage
  import synchronizer_pkg::*;
#(
  parameter int unsigned LEN = SYNC_DEF_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic [LEN-1:0] d_i,
  output logic [LEN-1:0] q_o
);

  logic [LEN-1:0] q_q;
  logic [LEN-1:0] q_d;

  // Hold the current value unless enabled.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  // Stage register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for a bundle of async inputs.
// Adds per-bit rise/fall strobes aligned to data_out.
module synchronizer
  import synchronizer_pkg::*;
#(
  parameter int unsigned LEN    = SYNC_DEF_LEN,
  parameter int unsigned STAGES = SYNC_DEF_STAGES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [LEN-1:0] data_in,
  output logic [LEN-1:0] data_out,
  output logic [LEN-1:0] rise,
  output logic [LEN-1:0] fall
);

  if (LEN < SYNC_MIN_LEN) begin : g_bad_len
    $error("synchronizer: LEN must be >= 1");
  end

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("synchronizer: STAGES must be >= 2");
  end

  // chain[0] is the raw input, chain[1..STAGES] the sync
  // flops, chain[STAGES+1] the history copy of data_out.
  logic [LEN-1:0] chain [STAGES+2];

  assign chain[0] = data_in;

  for (genvar i = 0; i <= STAGES; i++) begin : g_stage
    synchronizer_stage #(
      .LEN (LEN)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .d_i   (chain[i]),
      .q_o   (chain[i+1])
    );
  end

  logic [LEN-1:0] last_s;
  logic [LEN-1:0] prev_s;

  assign last_s = chain[STAGES];
  assign prev_s = chain[STAGES+1];

  // Edge strobes come from registers only, never from data_in.
  always_comb begin
    data_out = last_s;
    rise     = last_s & ~prev_s;
    fall     = ~last_s & prev_s;
  end

endmodule

// File: tb/tb_synchronizer.sv
// Directed bench for synchronizer (LEN=2/STAGES=2 and
// LEN=1/STAGES=3 instances).
module tb_synchronizer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] din;
  logic [1:0] dout;
  logic [1:0] rise;
  logic [1:0] fall;

  logic       din3;
  logic       dout3;
  logic       rise3;
  logic       fall3;

  int checks;
  int errors;

  synchronizer #(
    .LEN    (2),
    .STAGES (2)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .data_in  (din),
    .data_out (dout),
    .rise     (rise),
    .fall     (fall)
  );

  synchronizer #(
    .LEN    (1),
    .STAGES (3)
  ) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (1'b1),
    .data_in  (din3),
    .data_out (dout3),
    .rise     (rise3),
    .fall     (fall3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk3(input string tag,
                      input logic [1:0] o,
                      input logic [1:0] r,
                      input logic [1:0] f);
    chk({tag, ".out"}, 8'(dout), 8'(o));
    chk({tag, ".rise"}, 8'(rise), 8'(r));
    chk({tag, ".fall"}, 8'(fall), 8'(f));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    din    = 2'd3;
    din3   = 1'b0;
    #1;
    chk3("rst_now", 2'd0, 2'd0, 2'd0);
    step(3);
    chk3("rst_hold", 2'd0, 2'd0, 2'd0);

    din   = 2'd0;
    rst_n = 1'b1;
    step(3);
    chk3("settle0", 2'd0, 2'd0, 2'd0);

    din = 2'd2;
    step(1);
    chk3("lat_e1", 2'd0, 2'd0, 2'd0);
    step(1);
    chk3("lat_e2", 2'd2, 2'd2, 2'd0);
    step(1);
    chk3("lat_e3", 2'd2, 2'd0, 2'd0);

    din = 2'd1;
    step(2);
    chk3("seq_1", 2'd1, 2'd1, 2'd2);
    din = 2'd3;
    step(2);
    chk3("seq_3", 2'd3, 2'd2, 2'd0);
    din = 2'd0;
    step(2);
    chk3("seq_0", 2'd0, 2'd0, 2'd3);
    step(1);
    chk3("seq_0b", 2'd0, 2'd0, 2'd0);

    en  = 1'b0;
    din = 2'd3;
    step(5);
    chk3("en_off", 2'd0, 2'd0, 2'd0);
    en = 1'b1;
    step(1);
    chk3("en_on1", 2'd0, 2'd0, 2'd0);
    step(1);
    chk3("en_on2", 2'd3, 2'd3, 2'd0);
    en = 1'b0;
    step(2);
    chk3("en_hold_strobe", 2'd3, 2'd3, 2'd0);
    en = 1'b1;
    step(1);
    chk3("en_strobe_clr", 2'd3, 2'd0, 2'd0);

    din = 2'd0;
    step(3);
    chk3("mid_pre", 2'd0, 2'd0, 2'd0);
    din = 2'd3;
    step(1);
    rst_n = 1'b0;
    #1;
    chk3("mid_rst", 2'd0, 2'd0, 2'd0);
    step(1);
    chk3("mid_rst_hold", 2'd0, 2'd0, 2'd0);
    rst_n = 1'b1;
    step(1);
    chk3("mid_rel1", 2'd0, 2'd0, 2'd0);
    step(1);
    chk3("mid_rel2", 2'd3, 2'd3, 2'd0);

    din3 = 1'b1;
    step(2);
    chk("s3_e2.out", 8'(dout3), 8'd0);
    step(1);
    chk("s3_e3.out", 8'(dout3), 8'd1);
    chk("s3_e3.rise", 8'(rise3), 8'd1);
    chk("s3_e3.fall", 8'(fall3), 8'd0);
    step(1);
    chk("s3_e4.rise", 8'(rise3), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
